// File: rtl/mem_stage.sv
// mem_stage: memory-access stage. Holds the EXE->MEM pipeline register, runs loads
// and stores over a req/ack data port and forwards aligned results to write-back.
module mem_stage #(
    parameter int unsigned EXE_MEM_W = 155,
    parameter int unsigned MEM_WB_W  = 120
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 EXE_over,
    input  logic [EXE_MEM_W-1:0] EXE_MEM_bus,
    output logic                 MEM_allow_in,
    input  logic                 WB_allow_in,
    input  logic                 cancel,
    output logic                 MEM_over,
    output logic [MEM_WB_W-1:0]  MEM_WB_bus,
    output logic [4:0]           MEM_wdest,
    output logic                 MEM_rf_wen,
    output logic [31:0]          MEM_pc,
    output logic                 dm_req,
    output logic [3:0]           dm_wen,
    output logic [31:0]          dm_addr,
    output logic [31:0]          dm_wdata,
    input  logic                 dm_ack,
    input  logic [31:0]          dm_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_DRAIN} state_t;

    state_t               state, state_nx;
    logic                 MEM_valid;
    logic [EXE_MEM_W-1:0] bus_r;
    logic [31:0]          rdata_r;

    logic        inst_load, inst_store, ls_word, lb_sign;
    logic [31:0] store_data, exe_result, lo_result, pc;
    logic [5:0]  hilo_cp0_flags;
    logic [7:0]  cp0r_addr;
    logic        syscall, eret, rf_wen, overflow;
    logic [4:0]  rf_wdest;

    assign {inst_load, inst_store, ls_word, lb_sign, store_data, exe_result, lo_result,
            hilo_cp0_flags, cp0r_addr, syscall, eret, rf_wen, rf_wdest, overflow, pc} = bus_r;

    logic is_mem, addr_err, in_mem, in_addr_err, new_mem_op;
    logic [7:0]  load_byte;
    logic [31:0] mem_result;

    assign is_mem   = inst_load | inst_store;
    assign addr_err = MEM_valid & is_mem & ls_word & (exe_result[1:0] != 2'b00);

    // Decode of the incoming bus so the REQ state is entered on the latching edge.
    assign in_mem      = EXE_MEM_bus[154] | EXE_MEM_bus[153];
    assign in_addr_err = EXE_MEM_bus[152] & (EXE_MEM_bus[88:87] != 2'b00);

    assign MEM_over = MEM_valid & ~cancel & (state != S_DRAIN)
                    & (~is_mem | addr_err | (state == S_DONE));
    assign MEM_allow_in = (state != S_DRAIN) & (~MEM_valid | (MEM_over & WB_allow_in));
    assign new_mem_op   = MEM_allow_in & EXE_over & ~cancel & in_mem & ~in_addr_err;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (new_mem_op) state_nx = S_REQ;
            S_REQ: begin
                if (cancel)      state_nx = dm_ack ? S_IDLE : S_DRAIN;
                else if (dm_ack) state_nx = S_DONE;
            end
            S_DONE: begin
                if (cancel)                        state_nx = S_IDLE;
                else if (MEM_over && WB_allow_in)  state_nx = new_mem_op ? S_REQ : S_IDLE;
            end
            S_DRAIN: if (dm_ack) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            MEM_valid <= 1'b0;
            bus_r     <= '0;
            rdata_r   <= '0;
        end else begin
            state <= state_nx;
            if (MEM_allow_in) begin
                MEM_valid <= EXE_over & ~cancel;
                if (EXE_over) bus_r <= EXE_MEM_bus;
            end else if (cancel) begin
                // A request already on the port keeps running in DRAIN; the instruction itself is dead.
                MEM_valid <= 1'b0;
            end
            if (state == S_REQ && dm_ack) rdata_r <= dm_rdata;
        end
    end

    assign dm_req   = (state == S_REQ) | (state == S_DRAIN);
    assign dm_addr  = exe_result;
    assign dm_wen   = (dm_req & inst_store) ? (ls_word ? 4'b1111 : (4'b0001 << exe_result[1:0])) : '0;
    assign dm_wdata = ls_word ? store_data : {4{store_data[7:0]}};

    always_comb begin
        case (exe_result[1:0])
            2'd1:    load_byte = rdata_r[15:8];
            2'd2:    load_byte = rdata_r[23:16];
            2'd3:    load_byte = rdata_r[31:24];
            default: load_byte = rdata_r[7:0];
        endcase
        if (!inst_load)   mem_result = exe_result;
        else if (ls_word) mem_result = rdata_r;
        else              mem_result = {{24{lb_sign & load_byte[7]}}, load_byte};
    end

    assign MEM_WB_bus = {rf_wen, rf_wdest, mem_result, lo_result, hilo_cp0_flags, cp0r_addr,
                         syscall, eret, overflow, addr_err, pc};
    assign MEM_wdest  = MEM_valid ? rf_wdest : '0;
    assign MEM_rf_wen = MEM_valid & rf_wen;
    assign MEM_pc     = pc;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a transaction-level
// model of loads, stores, stalls, cancels and reset.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset, EXE_over, WB_allow_in, cancel, dm_ack;
    logic [154:0] EXE_MEM_bus;
    logic [31:0]  dm_rdata;
    logic         MEM_allow_in, MEM_over, MEM_rf_wen, dm_req;
    logic [119:0] MEM_WB_bus;
    logic [4:0]   MEM_wdest;
    logic [31:0]  MEM_pc, dm_addr, dm_wdata;
    logic [3:0]   dm_wen;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    mem_stage #(.EXE_MEM_W(155), .MEM_WB_W(120)) dut (
        .clk(clk), .reset(reset), .EXE_over(EXE_over), .EXE_MEM_bus(EXE_MEM_bus),
        .MEM_allow_in(MEM_allow_in), .WB_allow_in(WB_allow_in), .cancel(cancel),
        .MEM_over(MEM_over), .MEM_WB_bus(MEM_WB_bus), .MEM_wdest(MEM_wdest),
        .MEM_rf_wen(MEM_rf_wen), .MEM_pc(MEM_pc), .dm_req(dm_req), .dm_wen(dm_wen),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        ld, st, wd, sg;
        logic [31:0] sdata, exe, lo, pc, rdata;
        logic [5:0]  flags;
        logic [7:0]  cp0;
        logic        sys, eret, rfw, ovf;
        logic [4:0]  wdest;
        int unsigned lat, stall;
    } op_t;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic op_t mk(input logic ld, st, wd, sg, input logic [31:0] exe, sdata, rdata,
                               input int unsigned lat, stall);
        op_t o;
        o.ld = ld; o.st = st; o.wd = wd; o.sg = sg;
        o.exe = exe; o.sdata = sdata; o.rdata = rdata; o.lat = lat; o.stall = stall;
        o.lo = $urandom; o.pc = $urandom; o.flags = 6'($urandom); o.cp0 = 8'($urandom);
        o.sys = 1'($urandom); o.eret = 1'($urandom); o.rfw = 1'($urandom);
        o.ovf = 1'($urandom); o.wdest = 5'($urandom_range(1, 31));
        return o;
    endfunction

    function automatic op_t rand_op();
        int unsigned k;
        logic [31:0] a;
        k = $urandom_range(0, 4);
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        return mk(k < 2, (k == 2) || (k == 3), 1'($urandom), 1'($urandom), a, $urandom, $urandom,
                  $urandom_range(1, 4), $urandom_range(0, 2));
    endfunction

    function automatic logic [154:0] make_bus(input op_t o);
        return {o.ld, o.st, o.wd, o.sg, o.sdata, o.exe, o.lo, o.flags, o.cp0,
                o.sys, o.eret, o.rfw, o.wdest, o.ovf, o.pc};
    endfunction

    // Drives one instruction through the stage and checks every cycle until WB takes it.
    // chain: hand nxt over on the transfer edge; pre_latched: op was handed over that way.
    task automatic run_op(input op_t op, input bit pre_latched, input bit chain, input op_t nxt);
        logic        aerr, memop, last;
        logic [7:0]  b;
        logic [31:0] mres;
        logic [3:0]  wen;
        logic [119:0] wb, m;
        aerr  = (op.ld | op.st) & op.wd & (op.exe[1:0] != 2'b00);
        memop = (op.ld | op.st) & ~aerr;
        b     = 8'(op.rdata >> (8 * op.exe[1:0]));
        if (!op.ld)     mres = op.exe;
        else if (op.wd) mres = op.rdata;
        else            mres = op.sg ? {{24{b[7]}}, b} : {24'h0, b};
        wen = (op.st && memop) ? (op.wd ? 4'hF : 4'(1 << op.exe[1:0])) : 4'h0;
        wb  = {op.rfw, op.wdest, mres, op.lo, op.flags, op.cp0, op.sys, op.eret, op.ovf, aerr, op.pc};
        m   = '1;
        if (op.ld && aerr) m[113:82] = '0;

        if (!pre_latched) begin
            @(negedge clk);
            EXE_over = 1'b1; EXE_MEM_bus = make_bus(op); WB_allow_in = 1'b1;
            #1 chk("launch_allow_in", MEM_allow_in, 1);
        end
        if (memop) begin
            for (int unsigned i = 1; i <= op.lat; i++) begin
                @(negedge clk);
                EXE_over = 1'b0;
                dm_ack   = (i == op.lat);
                dm_rdata = (i == op.lat) ? op.rdata : $urandom;
                #1;
                chk("req_dm_req", dm_req, 1);
                chk("req_dm_addr", dm_addr, op.exe);
                chk("req_dm_wen", dm_wen, wen);
                if (op.st) chk("req_dm_wdata", dm_wdata, op.wd ? op.sdata : {4{op.sdata[7:0]}});
                chk("req_mem_over", MEM_over, 0);
            end
        end
        for (int unsigned i = 0; i <= op.stall; i++) begin
            @(negedge clk);
            EXE_over = 1'b0; dm_ack = 1'b0; dm_rdata = $urandom;
            last = (i == op.stall);
            WB_allow_in = last;
            if (last && chain) begin
                EXE_over = 1'b1; EXE_MEM_bus = make_bus(nxt);
            end
            #1;
            chk("done_mem_over", MEM_over, 1);
            chk("done_wb_bus", MEM_WB_bus & m, wb & m);
            chk("done_allow_in", MEM_allow_in, last);
            chk("done_wdest", MEM_wdest, op.wdest);
            chk("done_rf_wen", MEM_rf_wen, op.rfw);
            chk("done_pc", MEM_pc, op.pc);
            chk("done_dm_req", dm_req, 0);
        end
    endtask

    initial begin
        op_t o, n, z;
        bit  pre, ch;
        reset = 1'b1; EXE_over = 1'b0; WB_allow_in = 1'b1; cancel = 1'b0;
        dm_ack = 1'b0; dm_rdata = '0; EXE_MEM_bus = '0;
        z = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_allow_in", MEM_allow_in, 1);
        chk("rst_mem_over", MEM_over, 0);
        chk("rst_wb_bus", MEM_WB_bus, 0);
        chk("rst_dm_req", dm_req, 0);
        chk("rst_dm_wen", dm_wen, 0);
        chk("rst_dm_addr", dm_addr, 0);
        chk("rst_wdest", MEM_wdest, 0);
        @(negedge clk); reset = 1'b0;

        // lw with three-cycle latency
        run_op(mk(1, 0, 1, 0, 32'h100, 0, 32'h8765_4321, 3, 0), 0, 0, z);
        // lb signed / unsigned, zero-wait ack
        run_op(mk(1, 0, 0, 1, 32'h203, 0, 32'h80FF_1234, 1, 0), 0, 0, z);
        run_op(mk(1, 0, 0, 0, 32'h203, 0, 32'h80FF_1234, 1, 0), 0, 0, z);
        // sb lane 2, then misaligned sw
        run_op(mk(0, 1, 0, 0, 32'h2, 32'h1234_56AB, 0, 2, 0), 0, 0, z);
        run_op(mk(0, 1, 1, 0, 32'h6, 32'hDEAD_BEEF, 0, 1, 0), 0, 0, z);
        // ALU op held by WB for 4 cycles, next instruction accepted on the transfer edge
        o = mk(0, 0, 0, 0, 32'h55, 0, 0, 1, 4);
        n = mk(1, 0, 1, 0, 32'h44, 0, 32'hCAFE_F00D, 2, 1);
        run_op(o, 0, 1, n);
        run_op(n, 1, 0, z);

        // cancel in the second cycle of a pending lw; ack two cycles later
        @(negedge clk);
        EXE_over = 1'b1; EXE_MEM_bus = make_bus(mk(1, 0, 1, 0, 32'h300, 0, 0, 1, 0));
        #1 chk("cx_launch_allow_in", MEM_allow_in, 1);
        @(negedge clk); EXE_over = 1'b0; #1 chk("cx_req1", dm_req, 1);
        @(negedge clk); cancel = 1'b1; #1;
        chk("cx_req2", dm_req, 1); chk("cx_over2", MEM_over, 0); chk("cx_allow2", MEM_allow_in, 0);
        @(negedge clk); cancel = 1'b0; #1;
        chk("cx_drain_req", dm_req, 1); chk("cx_drain_addr", dm_addr, 32'h300);
        chk("cx_drain_over", MEM_over, 0); chk("cx_drain_allow", MEM_allow_in, 0);
        @(negedge clk); dm_ack = 1'b1; #1;
        chk("cx_ack_req", dm_req, 1); chk("cx_ack_over", MEM_over, 0); chk("cx_ack_allow", MEM_allow_in, 0);
        @(negedge clk); dm_ack = 1'b0; #1;
        chk("cx_after_req", dm_req, 0); chk("cx_after_allow", MEM_allow_in, 1);
        chk("cx_after_over", MEM_over, 0); chk("cx_after_wdest", MEM_wdest, 0);

        // cancel while a completed load is stalled by WB
        @(negedge clk);
        EXE_over = 1'b1; EXE_MEM_bus = make_bus(mk(1, 0, 1, 0, 32'h10, 0, 0, 1, 0));
        @(negedge clk); EXE_over = 1'b0; dm_ack = 1'b1; dm_rdata = 32'h1111_2222;
        #1 chk("cd_req", dm_req, 1);
        @(negedge clk); dm_ack = 1'b0; WB_allow_in = 1'b0; cancel = 1'b1; #1;
        chk("cd_over", MEM_over, 0); chk("cd_allow", MEM_allow_in, 0);
        @(negedge clk); cancel = 1'b0; WB_allow_in = 1'b1; #1;
        chk("cd_after_over", MEM_over, 0); chk("cd_after_allow", MEM_allow_in, 1);
        chk("cd_after_wdest", MEM_wdest, 0);

        // reset in the middle of a request
        @(negedge clk);
        EXE_over = 1'b1; EXE_MEM_bus = make_bus(mk(1, 0, 1, 0, 32'h40, 0, 0, 1, 0));
        @(negedge clk); EXE_over = 1'b0; #1 chk("rr_req", dm_req, 1);
        #1 reset = 1'b1;
        #1;
        chk("rr_dm_req", dm_req, 0); chk("rr_over", MEM_over, 0);
        chk("rr_wdest", MEM_wdest, 0); chk("rr_allow", MEM_allow_in, 1);
        @(negedge clk); reset = 1'b0; #1;
        chk("rr_rel_allow", MEM_allow_in, 1); chk("rr_rel_req", dm_req, 0);
        @(negedge clk); #1 chk("rr_idle_req", dm_req, 0);

        // randomized traffic, with random back-to-back hand-over
        o   = rand_op();
        pre = 1'b0;
        for (int unsigned t = 0; t < 80; t++) begin
            n  = rand_op();
            ch = 1'($urandom);
            run_op(o, pre, ch, n);
            pre = ch;
            o   = n;
        end
        run_op(o, pre, 0, z);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
